// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | Shared opcodes, FSM state encoding and helper functions for seq_alu_unit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam logic [3:0] MUL_ITERS = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic [3:0] iter_count(input logic [2:0] op, input logic [2:0] amt);
        case (op)
            OP_MUL:                 return MUL_ITERS;
            OP_SLL, OP_SRL, OP_ROR: return {1'b0, amt};
            default:                return 4'd0;
        endcase
    endfunction

    // Zero-iteration results; shifts only reach here when amt is 0.
    function automatic logic [7:0] single_cycle_result(input logic [2:0] op,
                                                       input logic [7:0] a,
                                                       input logic [7:0] b);
        case (op)
            OP_FWD:                 return b;
            OP_ADD:                 return a + b;
            OP_AND:                 return a & b;
            OP_OR:                  return a | b;
            OP_SLL, OP_SRL, OP_ROR: return a;
            default:                return 8'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_unit_if.sv
// +----------------------------------------------------------------------------+
// | seq_alu_unit_if                                                            |
// | Operand/opcode request and result/status bundle of the sequential ALU.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_alu_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [2:0]       SELECT;
    logic             START;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output DATA1, DATA2, SELECT, START,
        input  RESULT, ZERO, BUSY, DONE
    );

    modport slave (
        input  DATA1, DATA2, SELECT, START,
        output RESULT, ZERO, BUSY, DONE
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu_iter.sv
// +----------------------------------------------------------------------------+
// | seq_alu_iter                                                               |
// | Iterative datapath: shift-add multiply and 1-bit-per-step shift/rotate.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu_iter
    import alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [2:0] i_op,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_mplier,
    input  logic [3:0] i_iters,
    output logic [7:0] o_value,
    output logic       o_last
);

    logic [7:0] r_acc;
    logic [7:0] r_work;
    logic [3:0] r_cnt;

    logic [7:0] w_next_acc;
    logic [7:0] w_next_work;

    // For MUL the working register is the multiplicand shifted left by cnt.
    always_comb begin
        w_next_acc  = i_mplier[r_cnt[2:0]] ? (r_acc + r_work) : r_acc;
        w_next_work = r_work;
        case (i_op)
            OP_MUL, OP_SLL: w_next_work = {r_work[6:0], 1'b0};
            OP_SRL:         w_next_work = {1'b0, r_work[7:1]};
            OP_ROR:         w_next_work = {r_work[0], r_work[7:1]};
            default:        w_next_work = r_work;
        endcase
    end

    assign o_value = (i_op == OP_MUL) ? w_next_acc : w_next_work;
    assign o_last  = (r_cnt == (i_iters - 4'd1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc  <= 8'h00;
            r_work <= 8'h00;
            r_cnt  <= 4'd0;
        end else if (i_load) begin
            r_acc  <= 8'h00;
            r_work <= i_data1;
            r_cnt  <= 4'd0;
        end else if (i_step) begin
            r_acc  <= w_next_acc;
            r_work <= w_next_work;
            r_cnt  <= r_cnt + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu_unit.sv
// +----------------------------------------------------------------------------+
// | seq_alu_unit                                                               |
// | Multi-cycle 8-bit ALU: control FSM, operand latches and result register.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu_unit
    import alu_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    seq_alu_unit_if.slave  bus
);

    alu_state_t r_state;
    logic [2:0] r_op;
    logic [7:0] r_b;
    logic [3:0] r_iters;
    logic [7:0] r_result;

    logic [3:0] w_iters;
    logic       w_load;
    logic [7:0] w_iter_value;
    logic       w_last;

    assign w_iters = iter_count(bus.SELECT, bus.DATA2[2:0]);
    assign w_load  = (r_state == ST_IDLE) && bus.START && (w_iters != 4'd0);

    // DATA1 is captured into the iterator's working register on load.
    seq_alu_iter u_iter (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_load   (w_load),
        .i_step   (r_state == ST_EXEC),
        .i_op     (r_op),
        .i_data1  (bus.DATA1),
        .i_mplier (r_b),
        .i_iters  (r_iters),
        .o_value  (w_iter_value),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_FWD;
            r_b      <= 8'h00;
            r_iters  <= 4'd0;
            r_result <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.START) begin
                        r_op    <= bus.SELECT;
                        r_b     <= bus.DATA2;
                        r_iters <= w_iters;
                        if (w_iters == 4'd0) begin
                            r_result <= single_cycle_result(bus.SELECT, bus.DATA1, bus.DATA2);
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_last) begin
                        r_result <= w_iter_value;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.RESULT = r_result;
    assign bus.ZERO   = (r_result == 8'h00);
    assign bus.BUSY   = (r_state != ST_IDLE);
    assign bus.DONE   = (r_state == ST_DONE);

endmodule

`default_nettype wire
